fp_addsub_seq: RTL and testbench
================================

// Module: fp_addsub_seq
// PURPOSE
//  Multi-cycle sign-magnitude floating-point adder/subtractor (align, add/sub, normalise) with valid/ready handshakes.
//  Generalises the lab6 fraction add/sub datapath to parametrised exponent/fraction widths, correct effective-op
//  selection, iterative normalisation, overflow/underflow flags. Sits between operand registers and the result display.
// PARAMETERS
//  EXP_W   4  exponent width; bias = 2**(EXP_W-1)-1; exp==0 encodes zero (no denormals, no inf/NaN)
//  FRAC_W  6  stored fraction width; hidden 1 implied when exp!=0; word W = 1+EXP_W+FRAC_W
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  reset, asynchronous, active-low
//  in_valid   in   1  operands a/b/sub valid
//  in_ready   out  1  block idle, accepts operands
//  a          in   W  operand A {sign, exp, frac}
//  b          in   W  operand B {sign, exp, frac}
//  sub        in   1  1: A-B, 0: A+B
//  out_valid  out  1  result valid, held until out_ready
//  out_ready  in   1  consumer accepts result
//  result     out  W  {sign, exp, frac}
//  ovf        out  1  overflow saturation occurred (qualified by out_valid)
//  unf        out  1  underflow flush-to-zero occurred (qualified by out_valid)
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1 after release, out_valid=0, result=0, ovf=0, unf=0; any in-flight op discarded.
//  FSM IDLE->ALIGN->ADDSUB->NORM(n)->DONE->IDLE; in_ready=1 only in IDLE; in_valid ignored in other states.
//  IDLE: in_valid&in_ready captures a, b, sub. Effective B sign = b.s^sub; eff_sub = a.s^b.s^sub.
//  ALIGN: operand with exp==0 -> magnitude 0. Swap so big has larger {exp,frac}; diff = big.exp-small.exp.
//    Small mantissa {1,frac} shifted right by diff, truncated; diff>=FRAC_W+1 -> small = 0.
//  ADDSUB: FRAC_W+2-bit magnitudes; eff_sub ? big-small : big+small; sign = sign of big; exp = big.exp.
//  NORM, one decision per cycle:
//    carry bit set: shift right 1, exp+1; if exp was 2**EXP_W-1 -> saturate {sign,all-1 exp,all-1 frac}, ovf=1.
//    magnitude 0: result = +0 (all zeros), no flags.
//    hidden bit clear: shift left 1, exp-1; if exp==1 -> flush to +0, unf=1.
//    hidden bit set: go DONE. k left shifts cost k+1 NORM cycles.
//  DONE: out_valid=1; result/ovf/unf stable while out_ready=0; out_valid&out_ready -> IDLE, out_valid=0 next cycle.
//  Latency: accept edge to out_valid = 4 cycles with no left shift, +1 per left shift. No overlapping ops.
//  Zero results are always +0. Both operands zero -> +0.
// STRUCTURE
//  fp_pkg: state enum (IDLE, ALIGN, ADDSUB, NORM, DONE), fp_word struct {s, e, f} typedef, bias constant,
//    field pack/unpack functions parametrised by EXP_W/FRAC_W.
//  One sub-module: fp_align_shift (combinational right shift of mantissa by diff, saturating to 0 for large diff).
//  Top holds FSM, operand/working registers, adder, iterative normaliser.
// TESTING (EXP_W=4, FRAC_W=6, bias 7)
//  1.0+1.5: a=0_0111_000000, b=0_0111_100000, sub=0 -> result 0_1000_010000 (2.5), out_valid 4 cycles after accept.
//  1.5-1.0: b=0_0111_000000, sub=1 -> 0_0110_000000 (0.5), latency 5; -1.0+1.5 gives same result.
//  1.0-1.0: sub=1 -> result 0_0000_000000, ovf=0, unf=0.
//  a=0_1110_000000, b=0_0010_111111, sub=0 -> result = a exactly (B shifted out).
//  a=b=0_1111_111111, sub=0 -> 0_1111_111111, ovf=1; a=0_0001_100000, b=0_0001_000000, sub=1 -> +0, unf=1.
//  Handshake/reset: out_ready low 3 cycles -> result stable, in_ready=0; rst_n low during NORM -> all outputs reset.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and helpers for the sequential floating-point add/sub block.
//  state_t : controller states
//  fp_word : {sign, exp, frac} at the default widths (4/6)
//  FP_BIAS : exponent bias at the default width
//  fp_pack / fp_unpack_* : field helpers at the default widths
package fp_pkg;

  localparam int FP_EXP_W  = 4;
  localparam int FP_FRAC_W = 6;
  localparam int FP_BIAS   = (1 << (FP_EXP_W - 1)) - 1;

  typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, DONE} state_t;

  typedef struct packed {
    logic                 s;
    logic [FP_EXP_W-1:0]  e;
    logic [FP_FRAC_W-1:0] f;
  } fp_word;

  function automatic fp_word fp_pack(input logic s, input logic [FP_EXP_W-1:0] e,
                                     input logic [FP_FRAC_W-1:0] f);
    fp_word w;
    w.s = s;
    w.e = e;
    w.f = f;
    return w;
  endfunction

  function automatic logic [FP_EXP_W-1:0] fp_unpack_exp(input fp_word w);
    return w.e;
  endfunction

  function automatic logic [FP_FRAC_W-1:0] fp_unpack_frac(input fp_word w);
    return w.f;
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Combinational alignment shifter: right-shifts the smaller mantissa by the
// exponent difference, truncating. Differences that push every bit out give 0.
//  i_mant : {hidden, frac} of the smaller operand
//  i_diff : big.exp - small.exp
//  o_mant : aligned mantissa
module fp_align_shift #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 6
) (
  input  logic [FRAC_W:0]  i_mant,
  input  logic [EXP_W-1:0] i_diff,
  output logic [FRAC_W:0]  o_mant
);

  localparam logic [EXP_W:0] LIM = (EXP_W+1)'(FRAC_W + 1);

  always_comb begin
    o_mant = '0;
    if ({1'b0, i_diff} < LIM) o_mant = i_mant >> i_diff;
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle sign-magnitude FP adder/subtractor: align, add/sub, iterative
// normalise, then hold the result until the consumer takes it.
//  clk, rst_n            : clock, async active-low reset
//  in_valid/in_ready     : operand handshake (ready only when idle)
//  a, b, sub             : operands {s,e,f}; sub=1 computes a-b
//  out_valid/out_ready   : result handshake, result held while out_ready=0
//  result, ovf, unf      : result word, overflow-saturate / underflow-flush flags
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 6,
  localparam int W     = 1 + EXP_W + FRAC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         unf
);

  typedef struct packed {
    logic              s;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
  } word_t;

  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  state_t r_state, w_next;

  word_t             r_a, r_b;     // r_b carries the effective sign (b.s ^ sub)
  logic              r_eff_sub, r_sign;
  logic [EXP_W-1:0]  r_exp;
  logic [FRAC_W:0]   r_big_m, r_small_m;
  logic [FRAC_W+1:0] r_mag;        // {carry, hidden, frac}
  word_t             r_result;
  logic              r_ovf, r_unf;

  // Alignment: zero-exponent operands have zero magnitude and sort lowest.
  logic [FRAC_W:0]        w_a_m, w_b_m, w_small_sh;
  logic [EXP_W+FRAC_W-1:0] w_a_key, w_b_key;
  logic                   w_a_big;
  logic [EXP_W-1:0]       w_diff;

  assign w_a_m   = (r_a.e != '0) ? {1'b1, r_a.f} : '0;
  assign w_b_m   = (r_b.e != '0) ? {1'b1, r_b.f} : '0;
  assign w_a_key = (r_a.e != '0) ? {r_a.e, r_a.f} : '0;
  assign w_b_key = (r_b.e != '0) ? {r_b.e, r_b.f} : '0;
  assign w_a_big = (w_a_key >= w_b_key);
  assign w_diff  = w_a_big ? (r_a.e - r_b.e) : (r_b.e - r_a.e);

  fp_align_shift #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_align (
    .i_mant (w_a_big ? w_b_m : w_a_m),
    .i_diff (w_diff),
    .o_mant (w_small_sh)
  );

  logic w_carry, w_hidden, w_zero;
  assign w_carry  = r_mag[FRAC_W+1];
  assign w_hidden = r_mag[FRAC_W];
  assign w_zero   = (r_mag == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (in_valid) w_next = ALIGN;
      ALIGN:  w_next = ADDSUB;
      ADDSUB: w_next = NORM;
      // Only a clear hidden bit with room to shift keeps us normalising.
      NORM:   if (w_carry || w_zero || w_hidden || r_exp == EXP_ONE) w_next = DONE;
      DONE:   if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_eff_sub <= 1'b0;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_big_m   <= '0;
      r_small_m <= '0;
      r_mag     <= '0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a   <= word_t'(a);
          r_b   <= word_t'({b[W-1] ^ sub, b[W-2:0]});
          r_ovf <= 1'b0;
          r_unf <= 1'b0;
        end
        ALIGN: begin
          r_eff_sub <= r_a.s ^ r_b.s;
          r_sign    <= w_a_big ? r_a.s : r_b.s;
          r_exp     <= w_a_big ? r_a.e : r_b.e;
          r_big_m   <= w_a_big ? w_a_m : w_b_m;
          r_small_m <= w_small_sh;
        end
        ADDSUB: begin
          // Big >= small, so the difference never wraps.
          if (r_eff_sub) r_mag <= {1'b0, r_big_m} - {1'b0, r_small_m};
          else           r_mag <= {1'b0, r_big_m} + {1'b0, r_small_m};
        end
        NORM: begin
          if (w_carry) begin
            if (r_exp == '1) begin
              r_result <= '{s: r_sign, e: '1, f: '1};
              r_ovf    <= 1'b1;
            end else begin
              r_result <= '{s: r_sign, e: r_exp + 1'b1, f: r_mag[FRAC_W:1]};
            end
          end else if (w_zero) begin
            r_result <= '0;
          end else if (!w_hidden) begin
            if (r_exp == EXP_ONE) begin
              r_result <= '0;
              r_unf    <= 1'b1;
            end else begin
              r_mag <= r_mag << 1;
              r_exp <= r_exp - 1'b1;
            end
          end else begin
            r_result <= '{s: r_sign, e: r_exp, f: r_mag[FRAC_W-1:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule

// File: tb/tb_fp_addsub_seq.sv
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] a = '0, b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] result;
  logic        ovf, unf;

  int errors = 0;
  int checks = 0;
  int lat;

  always #5 clk = ~clk;

  fp_addsub_seq #(.EXP_W(4), .FRAC_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .unf(unf)
  );

  // Drive one operation and count edges from the accept edge (inclusive) to
  // the edge after which out_valid is seen. Gives 99 if it never arrives.
  task automatic run_op(input logic [10:0] ia, input logic [10:0] ib, input logic isub,
                        output int n);
    @(negedge clk);
    a = ia; b = ib; sub = isub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) n = 99;
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    checks++; if (result !== 11'd0) begin errors++; $display("FAIL rst_result got=%b want=0", result); end
    checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("FAIL rst_flags got=%b want=00", {ovf, unf}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_add();
    run_op(11'b0_0111_000000, 11'b0_0111_100000, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_lat got=%0d want=4", lat); end
    checks++; if (result !== 11'b0_1000_010000) begin errors++; $display("FAIL add_res got=%b want=%b", result, 11'b0_1000_010000); end
    checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("FAIL add_flags got=%b want=00", {ovf, unf}); end
    take_result();
    // 1.0 + 0.25 exercises a two-place alignment shift
    run_op(11'b0_0111_000000, 11'b0_0101_000000, 1'b0, lat);
    checks++; if (result !== 11'b0_0111_010000) begin errors++; $display("FAIL align_res got=%b want=%b", result, 11'b0_0111_010000); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL align_lat got=%0d want=4", lat); end
    take_result();
  endtask

  task automatic test_sub();
    run_op(11'b0_0111_100000, 11'b0_0111_000000, 1'b1, lat);
    checks++; if (result !== 11'b0_0110_000000) begin errors++; $display("FAIL sub_res got=%b want=%b", result, 11'b0_0110_000000); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL sub_lat got=%0d want=5", lat); end
    take_result();
    run_op(11'b1_0111_000000, 11'b0_0111_100000, 1'b0, lat);
    checks++; if (result !== 11'b0_0110_000000) begin errors++; $display("FAIL negadd_res got=%b want=%b", result, 11'b0_0110_000000); end
    take_result();
    // -1.5 + 1.0 keeps the sign of the bigger operand
    run_op(11'b1_0111_100000, 11'b0_0111_000000, 1'b0, lat);
    checks++; if (result !== 11'b1_0110_000000) begin errors++; $display("FAIL negbig_res got=%b want=%b", result, 11'b1_0110_000000); end
    take_result();
  endtask

  task automatic test_cancel();
    run_op(11'b0_0111_000000, 11'b0_0111_000000, 1'b1, lat);
    checks++; if (result !== 11'd0) begin errors++; $display("FAIL cancel_res got=%b want=0", result); end
    checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("FAIL cancel_flags got=%b want=00", {ovf, unf}); end
    take_result();
    run_op(11'b1_0000_000000, 11'b0_0000_000000, 1'b0, lat);
    checks++; if (result !== 11'd0) begin errors++; $display("FAIL zeros_res got=%b want=0", result); end
    take_result();
  endtask

  task automatic test_shift_out();
    run_op(11'b0_1110_000000, 11'b0_0010_111111, 1'b0, lat);
    checks++; if (result !== 11'b0_1110_000000) begin errors++; $display("FAIL shout_res got=%b want=%b", result, 11'b0_1110_000000); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL shout_lat got=%0d want=4", lat); end
    take_result();
  endtask

  task automatic test_ovf_unf();
    run_op(11'b0_1111_111111, 11'b0_1111_111111, 1'b0, lat);
    checks++; if (result !== 11'b0_1111_111111) begin errors++; $display("FAIL ovf_res got=%b want=%b", result, 11'b0_1111_111111); end
    checks++; if ({ovf, unf} !== 2'b10) begin errors++; $display("FAIL ovf_flags got=%b want=10", {ovf, unf}); end
    take_result();
    run_op(11'b0_0001_100000, 11'b0_0001_000000, 1'b1, lat);
    checks++; if (result !== 11'd0) begin errors++; $display("FAIL unf_res got=%b want=0", result); end
    checks++; if ({ovf, unf} !== 2'b01) begin errors++; $display("FAIL unf_flags got=%b want=01", {ovf, unf}); end
    take_result();
  endtask

  task automatic test_handshake();
    run_op(11'b0_0111_000000, 11'b0_0101_000000, 1'b0, lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 11'b0_1010_101010; b = 11'b0_1010_010101; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (result !== 11'b0_0111_010000) begin errors++; $display("FAIL hold_res[%0d] got=%b want=%b", i, result, 11'b0_0111_010000); end
      checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL hold_hs[%0d] got=%b want=10", i, {out_valid, in_ready}); end
    end
    @(negedge clk); in_valid = 1'b0;
    take_result();
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL release_hs got=%b want=01", {out_valid, in_ready}); end
    // Operands offered while busy must not have started an operation
    repeat (5) @(posedge clk);
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL ignore_busy got=%b want=01", {out_valid, in_ready}); end
  endtask

  task automatic test_reset_mid();
    // Six left shifts keep the block in NORM for several cycles
    @(negedge clk);
    a = 11'b0_0111_000001; b = 11'b0_0111_000000; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_ov got=%b want=0", out_valid); end
    checks++; if (result !== 11'd0) begin errors++; $display("FAIL midrst_res got=%b want=0", result); end
    checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("FAIL midrst_flags got=%b want=00", {ovf, unf}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL midrst_discard got=%b want=01", {out_valid, in_ready}); end
    run_op(11'b0_0111_000000, 11'b0_0111_100000, 1'b0, lat);
    checks++; if (result !== 11'b0_1000_010000 || lat !== 4) begin errors++; $display("FAIL postrst_op got=%b/%0d want=%b/4", result, lat, 11'b0_1000_010000); end
    take_result();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_cancel();
    test_shift_out();
    test_ovf_unf();
    test_handshake();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
